// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    // Width of the generic compare helper; MAX_LEN must not exceed this.
    localparam int unsigned CMP_W = 32;

    localparam logic [7:0]  DEF_PAT = 8'b0001_0110;
    localparam int unsigned DEF_LEN = 5;
    localparam bit          DEF_OVL = 1'b1;

    function automatic int unsigned calc_lw(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic masked_eq(input logic [CMP_W-1:0] pat,
                                       input logic [CMP_W-1:0] hist,
                                       input int unsigned      len);
        logic [CMP_W-1:0] mask;
        mask = (len >= CMP_W) ? '1 : ((CMP_W'(1) << len) - CMP_W'(1));
        return ((pat ^ hist) & mask) == '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= W'(inc);
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with run-time pattern, length and overlap mode.
module seq_detector_param #(
    parameter int unsigned        MAX_LEN = 8,
    parameter int unsigned        CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(seq_det_pkg::DEF_PAT),
    parameter int unsigned        DEF_LEN = seq_det_pkg::DEF_LEN,
    parameter bit                 DEF_OVL = seq_det_pkg::DEF_OVL,
    parameter int unsigned        LW      = seq_det_pkg::calc_lw(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inp,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    import seq_det_pkg::*;

    logic [MAX_LEN-1:0] pat_r, hist, hist_next;
    logic [LW-1:0]      len_r, fill, fill_next, len_clamped;
    logic [LW:0]        fill_inc;
    logic               ovl_r, hit;

    always_comb begin
        hist_next   = {hist[MAX_LEN-2:0], inp};
        fill_inc    = {1'b0, fill} + (LW+1)'(1);
        len_clamped = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
        // fill masks stale history, so only bits received since the last flush can match
        hit = in_valid && !cfg_load && (len_r != '0) && (fill_inc >= {1'b0, len_r}) &&
              masked_eq(CMP_W'(pat_r), CMP_W'(hist_next), 32'(len_r));
        fill_next = fill;
        if (cfg_load) begin
            fill_next = '0;
        end else if (in_valid) begin
            if (hit && !ovl_r) begin
                fill_next = '0;
            end else if (fill != LW'(MAX_LEN)) begin
                fill_next = fill_inc[LW-1:0];
            end
        end
    end

    assign armed = (len_r != '0) && (fill_inc >= {1'b0, len_r});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_r <= DEF_PAT;
            len_r <= LW'(DEF_LEN);
            ovl_r <= DEF_OVL;
            hist  <= '0;
            fill  <= '0;
            out   <= 1'b0;
        end else begin
            if (cfg_load) begin
                pat_r <= cfg_pat;
                len_r <= len_clamped;
                ovl_r <= cfg_ovl;
            end else if (in_valid) begin
                hist <= hist_next;
            end
            fill <= fill_next;
            out  <= hit;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .inc(hit),
        .q  (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: vector table, directed corners and random vs a queue model.
module tb_seq_detector_param;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LW      = 4;
    localparam int          CNT_MAX = 255;

    logic clk = 1'b0, rst = 1'b0, inp = 1'b0, in_valid = 1'b0;
    logic cfg_load = 1'b0, cfg_ovl = 1'b0, cnt_clr = 1'b0;
    logic [MAX_LEN-1:0] cfg_pat = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic               out, armed;
    logic [CNT_W-1:0]   match_cnt;

    always #5 clk = ~clk;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inp      (inp),
        .in_valid (in_valid),
        .cfg_load (cfg_load),
        .cfg_pat  (cfg_pat),
        .cfg_len  (cfg_len),
        .cfg_ovl  (cfg_ovl),
        .cnt_clr  (cnt_clr),
        .out      (out),
        .match_cnt(match_cnt),
        .armed    (armed)
    );

    int errors = 0, checks = 0, pulses = 0;

    // Reference model: bits received since the last flush, newest at the back.
    bit         hq[$];
    logic [7:0] m_pat;
    int         m_len, m_cnt;
    bit         m_ovl, m_out;

    typedef struct {
        bit b;
        bit exp_out;
        int exp_cnt;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        m_pat = 8'b0001_0110;
        m_len = 5;
        m_ovl = 1'b1;
        m_cnt = 0;
        m_out = 1'b0;
    endtask

    function automatic bit m_armed();
        return (m_len != 0) && (hq.size() + 1 >= m_len);
    endfunction

    task automatic model_step(input bit b, input bit v, input bit ld, input bit cc,
                              input logic [7:0] pat, input int len, input bit ovl);
        bit hit = 1'b0;
        if (ld) begin
            hq.delete();
            m_pat = pat;
            m_len = (len > MAX_LEN) ? MAX_LEN : len;
            m_ovl = ovl;
        end else if (v) begin
            hq.push_back(b);
            if (hq.size() > MAX_LEN) void'(hq.pop_front());
            if (m_len > 0 && hq.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (hq[hq.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
            if (hit && !m_ovl) hq.delete();
        end
        if (cc) m_cnt = 0;
        if (hit && m_cnt < CNT_MAX) m_cnt++;
        m_out = hit;
    endtask

    task automatic tick(input bit b, input bit v, input bit ld, input bit cc);
        inp = b; in_valid = v; cfg_load = ld; cnt_clr = cc;
        model_step(b, v, ld, cc, cfg_pat, int'(cfg_len), cfg_ovl);
        @(posedge clk);
        #1;
        chk("out", int'(out), int'(m_out));
        chk("match_cnt", int'(match_cnt), m_cnt);
        chk("armed", int'(armed), int'(m_armed()));
        if (out) pulses++;
        inp = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [7:0] pat, input int len, input bit ovl);
        cfg_pat = pat; cfg_len = LW'(len); cfg_ovl = ovl;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send(input logic [15:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) tick(seq[i], 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] s;
        bit b, v, ld, cc;

        // Defaults, overlap on: 1,0,1,1,0,1,1,0
        s = 16'b1011_0110;
        for (int i = 0; i < 8; i++) tbl[i].b = s[7-i];
        tbl[0].exp_out = 0; tbl[0].exp_cnt = 0;
        tbl[1].exp_out = 0; tbl[1].exp_cnt = 0;
        tbl[2].exp_out = 0; tbl[2].exp_cnt = 0;
        tbl[3].exp_out = 0; tbl[3].exp_cnt = 0;
        tbl[4].exp_out = 1; tbl[4].exp_cnt = 1;
        tbl[5].exp_out = 0; tbl[5].exp_cnt = 1;
        tbl[6].exp_out = 0; tbl[6].exp_cnt = 1;
        tbl[7].exp_out = 1; tbl[7].exp_cnt = 2;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_held_out", int'(out), 0);
        chk("rst_held_cnt", int'(match_cnt), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_cnt", int'(match_cnt), 0);
        chk("rst_armed", int'(armed), 0);

        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].b, 1'b1, 1'b0, 1'b0);
            chk("tbl_out", int'(out), int'(tbl[i].exp_out));
            chk("tbl_cnt", int'(match_cnt), tbl[i].exp_cnt);
        end

        // Pattern 101, overlap off then on
        load(8'b101, 3, 1'b0);
        pulses = 0;
        send(16'b10101, 5);
        chk("nonovl_pulses", pulses, 1);
        load(8'b101, 3, 1'b1);
        pulses = 0;
        send(16'b10101, 5);
        chk("ovl_pulses", pulses, 2);

        // in_valid gaps before the final bit
        load(8'b0001_0110, 5, 1'b1);
        pulses = 0;
        send(16'b1011, 4);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            chk("gap_armed", int'(armed), 1);
            chk("gap_out", int'(out), 0);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("gap_final_out", int'(out), 1);
        chk("gap_pulses", pulses, 1);

        // cfg_load coincident with the completing bit drops it
        send(16'b1011, 4);
        pulses = 0;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("load_drop_out", int'(out), 0);
        chk("load_drop_armed", int'(armed), 0);

        // Zero length never matches
        load(8'($urandom), 0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 20; i++) tick(1'($urandom), 1'b1, 1'b0, 1'b0);
        chk("len0_pulses", pulses, 0);
        chk("len0_armed", int'(armed), 0);

        // Oversized length clamps to MAX_LEN
        load(8'b1011_0011, 12, 1'b1);
        pulses = 0;
        send(16'b1011_0011, 8);
        chk("len12_out", int'(out), 1);
        chk("len12_pulses", pulses, 1);

        // Counter saturation and clear-with-match
        load(8'b1, 1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_cnt", int'(match_cnt), 0);
        for (int i = 0; i < 260; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_cnt", int'(match_cnt), 255);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_hit_cnt", int'(match_cnt), 1);

        // Asynchronous reset mid-pattern
        load(8'b0001_0110, 5, 1'b1);
        send(16'b101, 3);
        @(negedge clk) rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_out", int'(out), 0);
        chk("async_rst_cnt", int'(match_cnt), 0);
        chk("async_rst_armed", int'(armed), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        pulses = 0;
        send(16'b1010110, 7);
        chk("post_rst_pulses", pulses, 1);
        chk("post_rst_out", int'(out), 1);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            ld = ($urandom % 40) == 0;
            if (ld) begin
                cfg_pat = 8'($urandom);
                cfg_len = ($urandom % 4 == 0) ? LW'($urandom_range(0, 12))
                                              : LW'($urandom_range(1, 4));
                cfg_ovl = 1'($urandom);
            end
            b  = 1'($urandom);
            v  = ($urandom % 10) < 7;
            cc = ($urandom % 50) == 0;
            tick(b, v, ld, cc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
